// File: rtl/nand_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : nand_seq_pkg
// Brief  : Op codes, FSM states and pass-schedule types for nand_seq_alu.
// Rev    : 1.0 - initial release
// ============================================================================
package nand_seq_pkg;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_passes_not = 3'd1;
  localparam logic [2:0] c_passes_and = 3'd2;
  localparam logic [2:0] c_passes_or  = 3'd3;
  localparam logic [2:0] c_passes_xor = 3'd4;

  localparam int c_step_w = 2;
  typedef logic [c_step_w-1:0] step_t;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_T = 2'd2,
    SRC_U = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    DST_T = 2'd0,
    DST_U = 2'd1,
    DST_Y = 2'd2
  } dst_t;

  typedef struct packed {
    src_t x;
    src_t y;
    dst_t dst;
  } pass_t;

  function automatic logic [2:0] pass_count(input logic [1:0] op);
    logic [2:0] n;
    case (op)
      OP_NOT:  n = c_passes_not;
      OP_AND:  n = c_passes_and;
      OP_OR:   n = c_passes_or;
      default: n = c_passes_xor;
    endcase
    return n;
  endfunction

  function automatic step_t last_step(input logic [1:0] op);
    logic [2:0] n;
    n = pass_count(op);
    return step_t'(n - 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nand_unit.sv
`default_nettype none
// ============================================================================
// Module : nand_unit
// Brief  : Combinational WIDTH-bit bitwise NAND stage.
// Rev    : 1.0 - initial release
// ============================================================================
module nand_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  assign z = ~(x & y);

endmodule
`default_nettype wire

// File: rtl/nand_seq_alu.sv
`default_nettype none
// ============================================================================
// Module : nand_seq_alu
// Brief  : NOT/AND/OR/XOR built from one time-shared NAND stage, one pass/cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module nand_seq_alu
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_op;
  step_t            r_step;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_y;

  logic             w_accept;
  logic             w_last;
  pass_t            w_pass;
  logic [WIDTH-1:0] w_opx;
  logic [WIDTH-1:0] w_opy;
  logic [WIDTH-1:0] w_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = (r_step == last_step(r_op));
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pass schedule: which registers feed the NAND and where its result lands.
  always_comb begin
    w_pass = '{x: SRC_A, y: SRC_A, dst: DST_Y};
    case (r_op)
      OP_AND: begin
        case (r_step)
          2'd0:    w_pass = '{x: SRC_A, y: SRC_B, dst: DST_T};
          default: w_pass = '{x: SRC_T, y: SRC_T, dst: DST_Y};
        endcase
      end
      OP_OR: begin
        case (r_step)
          2'd0:    w_pass = '{x: SRC_A, y: SRC_A, dst: DST_T};
          2'd1:    w_pass = '{x: SRC_B, y: SRC_B, dst: DST_U};
          default: w_pass = '{x: SRC_T, y: SRC_U, dst: DST_Y};
        endcase
      end
      OP_XOR: begin
        case (r_step)
          2'd0:    w_pass = '{x: SRC_A, y: SRC_B, dst: DST_T};
          2'd1:    w_pass = '{x: SRC_A, y: SRC_T, dst: DST_U};
          2'd2:    w_pass = '{x: SRC_B, y: SRC_T, dst: DST_T};
          default: w_pass = '{x: SRC_U, y: SRC_T, dst: DST_Y};
        endcase
      end
      default: w_pass = '{x: SRC_A, y: SRC_A, dst: DST_Y};
    endcase
  end

  always_comb begin
    w_opx = r_a;
    case (w_pass.x)
      SRC_A:   w_opx = r_a;
      SRC_B:   w_opx = r_b;
      SRC_T:   w_opx = r_t;
      default: w_opx = r_u;
    endcase
  end

  always_comb begin
    w_opy = r_a;
    case (w_pass.y)
      SRC_A:   w_opy = r_a;
      SRC_B:   w_opy = r_b;
      SRC_T:   w_opy = r_t;
      default: w_opy = r_u;
    endcase
  end

  nand_unit #(
    .WIDTH(WIDTH)
  ) u_nand (
    .x(w_opx),
    .y(w_opy),
    .z(w_z)
  );

  // XOR pass 2 reads r_t and writes r_t; the register boundary keeps the old value visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_NOT;
      r_step <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_t    <= '0;
      r_u    <= '0;
      r_y    <= '0;
    end else if (w_accept) begin
      r_a    <= A;
      r_b    <= B;
      r_op   <= op;
      r_step <= '0;
    end else if (r_state == S_EXEC) begin
      case (w_pass.dst)
        DST_T:   r_t <= w_z;
        DST_U:   r_u <= w_z;
        default: r_y <= w_z;
      endcase
      if (!w_last) begin
        r_step <= r_step + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign Y         = r_y;

endmodule
`default_nettype wire
